// File: rtl/my_iterative_shifter.sv
// my_iterative_shifter
//
// Multi-cycle shift unit for the execute stage. A request (word, shift amount,
// mode) is accepted over a valid/ready handshake. The working register then
// moves by up to STEP bit positions per clock until the whole amount has been
// applied. The result is held on out_valid/out_ready until the consumer takes it.
//
// Parameters:
//   WIDTH  data width (power of two, >= 4)
//   STEP   maximum positions shifted per clock (power of two, 1..WIDTH/2)
//   SW     shift-amount width, $clog2(WIDTH) (derived)
//
// Ports:
//   clock      sole clock, rising edge
//   reset      synchronous, active-high
//   in_valid   request present
//   in_ready   block can accept (state == IDLE)
//   data_in    operand
//   shamt      shift amount 0..WIDTH-1
//   mode       00 SLL, 01 SRL, 10 SRA, 11 ROR (or SRA, see below)
//   out_valid  result valid (state == DONE)
//   out_ready  consumer takes result
//   data_out   result, held while out_valid and out_ready=0
//   busy       high in SHIFT or DONE
//
// Build option:
//   SHIFTER_ROTATE_EN  when defined, mode 11 rotates right with wrap-around.
//                      When undefined, no rotate logic is built and mode 11
//                      behaves exactly like mode 10 (SRA).

module my_iterative_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SW-1:0]    shamt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             busy
);

    // Width of a per-cycle step amount (0..STEP).
    localparam int NW = $clog2(STEP + 1);
    localparam logic [SW-1:0] STEP_SW = SW'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  work_reg;
    logic [WIDTH-1:0]  work_next;
    logic [WIDTH-1:0]  result_reg;
    logic [SW-1:0]     remaining_reg;
    logic [SW-1:0]     step_amt;
    logic [NW-1:0]     step_idx;
    logic              left_reg;   // 1: shift left, 0: shift right
    logic              sign_reg;   // fill bit for right shifts (0 for SRL)
`ifdef SHIFTER_ROTATE_EN
    logic              rot_reg;    // right shift wraps LSBs into MSBs
`endif

    // Fill bit latched at accept: MSB of the operand for arithmetic shifts,
    // zero otherwise. SRL and SRA then share one right-shift path.
    logic sign_in;
`ifdef SHIFTER_ROTATE_EN
    assign sign_in = (mode == 2'b10) & data_in[WIDTH-1];
`else
    assign sign_in = mode[1] & data_in[WIDTH-1];
`endif

    // Amount moved this cycle: min(STEP, remaining).
    assign step_amt = (remaining_reg > STEP_SW) ? STEP_SW : remaining_reg;
    assign step_idx = step_amt[NW-1:0];

    // Precompute the working register shifted by every legal step amount
    // 0..STEP and pick one. This keeps the per-cycle shifter to a small mux
    // instead of a full barrel shifter.
    logic [WIDTH-1:0] cand [STEP+1];

    assign cand[0] = work_reg;

    generate
        for (genvar gi = 1; gi <= STEP; gi++) begin : g_step
            logic [gi-1:0] fill;
`ifdef SHIFTER_ROTATE_EN
            assign fill = rot_reg ? work_reg[gi-1:0] : {gi{sign_reg}};
`else
            assign fill = {gi{sign_reg}};
`endif
            assign cand[gi] = left_reg ? {work_reg[WIDTH-1-gi:0], {gi{1'b0}}}
                                       : {fill, work_reg[WIDTH-1:gi]};
        end
    endgenerate

    assign work_next = cand[step_idx];

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        data_out   = result_reg;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (remaining_reg == step_amt) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            work_reg      <= '0;
            result_reg    <= '0;
            remaining_reg <= '0;
            left_reg      <= 1'b0;
            sign_reg      <= 1'b0;
`ifdef SHIFTER_ROTATE_EN
            rot_reg       <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        work_reg      <= data_in;
                        remaining_reg <= shamt;
                        left_reg      <= (mode == 2'b00);
                        sign_reg      <= sign_in;
`ifdef SHIFTER_ROTATE_EN
                        rot_reg       <= (mode == 2'b11);
`endif
                        // Zero shift goes straight to DONE, so the result
                        // is the operand itself.
                        if (shamt == '0) begin
                            result_reg <= data_in;
                        end
                    end
                end
                SHIFT: begin
                    work_reg      <= work_next;
                    remaining_reg <= remaining_reg - step_amt;
                    // Capture into a separate register so data_out never
                    // shows intermediate values and keeps the last result
                    // after returning to IDLE.
                    if (remaining_reg == step_amt) begin
                        result_reg <= work_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_iterative_shifter.sv
// Testbench for my_iterative_shifter. Two instances (STEP=1 and STEP=4) share
// stimulus; each has its own scoreboard queue of expected result, expected
// latency and accept cycle, checked when the instance presents its result.

module tb_my_iterative_shifter;

    localparam int WIDTH = 32;
    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [WIDTH-1:0]  data_in;
    logic [4:0]        shamt;
    logic [1:0]        mode;
    logic              out_ready;

    logic              ir1, ov1, bz1;
    logic              ir4, ov4, bz4;
    logic [WIDTH-1:0]  dout1, dout4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          acc;
    } sb_t;

    sb_t q1[$];
    sb_t q4[$];

    my_iterative_shifter #(.WIDTH(WIDTH), .STEP(1)) u_dut_s1 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir1),
        .data_in(data_in), .shamt(shamt), .mode(mode),
        .out_valid(ov1), .out_ready(out_ready),
        .data_out(dout1), .busy(bz1)
    );

    my_iterative_shifter #(.WIDTH(WIDTH), .STEP(4)) u_dut_s4 (
        .clock(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir4),
        .data_in(data_in), .shamt(shamt), .mode(mode),
        .out_valid(ov4), .out_ready(out_ready),
        .data_out(dout4), .busy(bz4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single-cycle reference shift.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s,
                                              input logic [1:0] m);
`ifdef SHIFTER_ROTATE_EN
        logic [63:0] xx;
`endif
        case (m)
            M_SLL: return x << s;
            M_SRL: return x >> s;
            M_SRA: return $signed(x) >>> s;
            default: begin
`ifdef SHIFTER_ROTATE_EN
                xx = {x, x} >> s;
                return xx[31:0];
`else
                return $signed(x) >>> s;
`endif
            end
        endcase
    endfunction

    // Monitor for the STEP=1 instance.
    logic        vis1 = 1'b0;
    logic [31:0] held1 = '0;
    always @(negedge clk) begin
        if (reset) begin
            vis1 <= 1'b0;
        end else begin
            check_eq("s1_busy", 32'(bz1), 32'(!ir1));
            if (ov1) begin
                check_eq("s1_in_ready_done", 32'(ir1), 32'd0);
                if (!vis1) begin
                    if (q1.size() == 0) check_eq("s1_spurious_valid", 32'd1, 32'd0);
                    else check_eq("s1_latency", 32'(cyc - q1[0].acc + 1), 32'(q1[0].lat));
                    held1 <= dout1;
                end else begin
                    check_eq("s1_hold", dout1, held1);
                end
                if (out_ready) begin
                    if (q1.size() != 0) begin
                        check_eq("s1_data", dout1, q1[0].exp);
                        $display("s1 xfer data_out=%h exp=%h", dout1, q1[0].exp);
                        void'(q1.pop_front());
                    end
                    vis1 <= 1'b0;
                end else begin
                    vis1 <= 1'b1;
                end
            end else begin
                vis1 <= 1'b0;
            end
        end
    end

    // Monitor for the STEP=4 instance.
    logic        vis4 = 1'b0;
    logic [31:0] held4 = '0;
    always @(negedge clk) begin
        if (reset) begin
            vis4 <= 1'b0;
        end else begin
            check_eq("s4_busy", 32'(bz4), 32'(!ir4));
            if (ov4) begin
                check_eq("s4_in_ready_done", 32'(ir4), 32'd0);
                if (!vis4) begin
                    if (q4.size() == 0) check_eq("s4_spurious_valid", 32'd1, 32'd0);
                    else check_eq("s4_latency", 32'(cyc - q4[0].acc + 1), 32'(q4[0].lat));
                    held4 <= dout4;
                end else begin
                    check_eq("s4_hold", dout4, held4);
                end
                if (out_ready) begin
                    if (q4.size() != 0) begin
                        check_eq("s4_data", dout4, q4[0].exp);
                        $display("s4 xfer data_out=%h exp=%h", dout4, q4[0].exp);
                        void'(q4.pop_front());
                    end
                    vis4 <= 1'b0;
                end else begin
                    vis4 <= 1'b1;
                end
            end else begin
                vis4 <= 1'b0;
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (ir1 && ir4) break;
            @(posedge clk); #1;
        end
        if (!(ir1 && ir4)) check_eq("wait_ready_timeout", 32'(ir1 & ir4), 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
        sb_t e;
        wait_ready();
        in_valid = 1'b1;
        data_in  = d;
        shamt    = s;
        mode     = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.exp = ref_shift(d, s, m);
        e.acc = cyc;
        e.lat = 1 + int'(s);
        q1.push_back(e);
        e.lat = 1 + (int'(s) + 3) / 4;
        q4.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q1.size() == 0 && q4.size() == 0) break;
            @(posedge clk); #1;
        end
        if (q1.size() != 0 || q4.size() != 0)
            check_eq("drain_timeout", 32'(q1.size() + q4.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_s1_in_ready"},  32'(ir1), 32'd1);
        check_eq({tag, "_s1_out_valid"}, 32'(ov1), 32'd0);
        check_eq({tag, "_s1_busy"},      32'(bz1), 32'd0);
        check_eq({tag, "_s1_data_out"},  dout1,    32'd0);
        check_eq({tag, "_s4_in_ready"},  32'(ir4), 32'd1);
        check_eq({tag, "_s4_out_valid"}, 32'(ov4), 32'd0);
        check_eq({tag, "_s4_busy"},      32'(bz4), 32'd0);
        check_eq({tag, "_s4_data_out"},  dout4,    32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        shamt     = '0;
        mode      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");

        // Directed cases.
        send(32'h8000_0001, 5'd4, M_SRA);
        drain();
        send(32'h8000_0001, 5'd4, M_SRL);
        drain();
        send(32'h8000_0001, 5'd4, M_SLL);
        drain();
        send(32'h1234_5678, 5'd7, M_SRL);
        drain();
        send(32'h1234_5678, 5'd0, M_SRL);
        drain();
        send(32'h0000_000F, 5'd4, M_ROR);
        drain();
        send(32'h8765_4321, 5'd13, M_ROR);
        drain();
        send(32'h8000_0000, 5'd31, M_SRA);
        drain();
        send(32'hFFFF_FFFF, 5'd31, M_SLL);
        drain();

        // Back-to-back requests without draining in between.
        send(32'hA5A5_0F0F, 5'd3, M_SRA);
        send(32'h0F0F_A5A5, 5'd1, M_SLL);
        drain();

        // Random operands, amounts and modes.
        for (int i = 0; i < 10; i++) begin
            send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        drain();

        // Backpressure plus input churn while busy.
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 5'd20, M_SLL);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            data_in  = $urandom;
            shamt    = 5'($urandom_range(0, 31));
            mode     = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ov1 && ov4) break;
            @(posedge clk); #1;
        end
        check_eq("stall_both_valid", 32'(ov1 & ov4), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("stall_s1_in_ready", 32'(ir1), 32'd0);
        check_eq("stall_s4_in_ready", 32'(ir4), 32'd0);
        out_ready = 1'b1;
        drain();

        // Reset two cycles into a long SLL: result discarded.
        send(32'h0000_ABCD, 5'd20, M_SLL);
        @(posedge clk); #1;
        reset = 1'b1;
        q1.delete();
        q4.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("midreset");
        @(posedge clk); #1;
        check_eq("post_reset_s1_in_ready", 32'(ir1), 32'd1);
        check_eq("post_reset_s4_in_ready", 32'(ir4), 32'd1);
        repeat (25) @(posedge clk);
        #1;
        send(32'h1357_9BDF, 5'd9, M_SRL);
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/my_iterative_shifter.md
# my_iterative_shifter

Multi-cycle, parametrised shift unit for the execute stage: accepts a word, a shift amount and a mode over a valid/ready handshake. It then shifts the word by up to STEP bit positions per clock until the full amount is applied. The result is presented on a held output handshake. It replaces single-position, single-direction shift stages with one block that covers logical left, logical right and arithmetic right shifts, plus optional rotate, at a configurable area/latency trade-off.

## Interface
- WIDTH, 32, data width; power of two, ≥ 4
- STEP, 1, maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH/2
- SW (localparam), $clog2(WIDTH), shift-amount width
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- data_in  input  WIDTH  operand
- shamt  input  SW  shift amount, 0..WIDTH-1
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- data_out  output  WIDTH  result
- busy  output  1  high in SHIFT or DONE

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state IDLE.
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, data_out=0, internal remaining count=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch data_in into the working register, shamt into remaining, and mode.
  - For SRA, latch sign = data_in[WIDTH-1].
  - Next state is DONE if shamt==0, else SHIFT.
- SHIFT:
  - Each cycle, shift the working register by n = min(STEP, remaining) and set remaining -= n.
  - When remaining reaches 0 after the update, go to DONE.
  - in_ready=0.
- Fill rules:
  - SLL: zeros into the LSBs.
  - SRL: zeros into the MSBs.
  - SRA: the latched sign into the MSBs, on every step.
  - ROR: bits leaving LSB re-enter at MSB.
- DONE:
  - out_valid=1 and data_out = working register.
  - Hold data_out stable while out_ready=0.
  - On out_ready, return to IDLE and drop out_valid.
- data_out retains the last result in IDLE; it is only meaningful while out_valid=1.
- Inputs data_in, shamt and mode are ignored except on an accept cycle; they may change freely while busy.
- Reset asserted in any state, including mid-SHIFT or DONE with a pending result:
  - the result is discarded;
  - next cycle is IDLE with all reset values.
- Result must equal the single-cycle reference: SLL x<<s, SRL x>>s, SRA $signed(x)>>>s, ROR rotate-right by s.

## Timing
- An accept occurs on an edge where state=IDLE and in_valid=1.
- Latency: out_valid rises 1 + ceil(shamt/STEP) cycles after the accept edge.
  - shamt=0 → 1 cycle.
  - WIDTH=32, STEP=1, shamt=31 → 32 cycles.
- in_ready is a pure decode of state==IDLE, with no combinational path from in_valid or out_ready.
- A new accept is possible no earlier than the edge after the DONE→IDLE handoff. Minimum request-to-request spacing is latency + 2 cycles with out_ready tied high.
- out_valid/out_ready follow a standard handshake: transfer happens on the edge where both are 1.
- All outputs are registered or state-decoded; no input-to-output combinational paths.

## Configuration
- SHIFTER_ROTATE_EN defined:
  - mode 11 performs rotate-right with wrap-around as above.
  - Adds the wrap mux per step.
- SHIFTER_ROTATE_EN undefined:
  - no rotate logic is built.
  - mode 11 is decoded as SRA and produces an identical result to mode 10 for all inputs.

## Test plan
- Reset, then idle for 3 cycles → in_ready=1, out_valid=0, busy=0, data_out=0.
- WIDTH=32, STEP=1, data_in=0x80000001, mode=SRA, shamt=4 → out_valid 5 cycles after accept, data_out=0xF8000000. Same with SRL → 0x08000000; with SLL → 0x00000010.
- STEP=4, data_in=0x12345678, mode=SRL, shamt=7 → latency 3 (steps of 4 then 3), data_out=0x002468AC. shamt=0 → latency 1, data_out=0x12345678.
- Rotate, data_in=0x0000000F, mode=11, shamt=4: with SHIFTER_ROTATE_EN → 0xF0000000; without it → 0x00000000 (SRA, positive operand).
- Backpressure and input churn: hold out_ready=0 for 10 cycles in DONE → data_out stable, in_ready=0. Toggle in_valid and data_in during SHIFT → result unaffected, no extra accept.
- Reset mid-op: assert reset 2 cycles into a shamt=20 SLL → out_valid never rises for that request, in_ready=1 the cycle after reset deasserts. A fresh request then completes correctly.
